// File: rtl/cpu_fetch.sv
// Instruction fetch stage: walks the instruction memory, assembles opcode plus
// optional trailing literal, and hands one complete instruction to execute.
module cpu_fetch #(
    parameter logic [15:0] RESET_ADDR = 16'h0000,
    parameter logic [7:0]  LIT_CODE   = 8'h1A
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] i_addr,
    input  logic [15:0] i_bus,
    output logic [15:0] instr,
    output logic [15:0] literal,
    output logic        has_literal,
    output logic [15:0] pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        jump,
    input  logic [15:0] jump_addr
);

    typedef enum logic [2:0] {
        OP_WAIT  = 3'd0,
        OP_CAP   = 3'd1,
        LIT_WAIT = 3'd2,
        LIT_CAP  = 3'd3,
        VALID    = 3'd4
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   op_is_lit;
    logic   accept;

    assign op_is_lit = (i_bus[7:0] == LIT_CODE);
    assign accept    = (state == VALID) && instr_ready;

    always_comb begin
        state_nxt = state;
        case (state)
            OP_WAIT:  state_nxt = OP_CAP;
            OP_CAP:   state_nxt = op_is_lit ? LIT_WAIT : VALID;
            LIT_WAIT: state_nxt = LIT_CAP;
            LIT_CAP:  state_nxt = VALID;
            VALID:    state_nxt = instr_ready ? OP_WAIT : VALID;
            default:  state_nxt = OP_WAIT;
        endcase
        // A redirect discards whatever is in flight, including a presented instruction.
        if (jump)
            state_nxt = OP_WAIT;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= OP_WAIT;
            instr_valid <= 1'b0;
        end else begin
            state       <= state_nxt;
            instr_valid <= (state_nxt == VALID);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            i_addr      <= RESET_ADDR;
            pc          <= RESET_ADDR;
            instr       <= 16'h0000;
            literal     <= 16'h0000;
            has_literal <= 1'b0;
        end else if (jump) begin
            i_addr <= jump_addr;
            pc     <= jump_addr;
        end else begin
            case (state)
                OP_CAP: begin
                    instr       <= i_bus;
                    has_literal <= op_is_lit;
                    pc          <= i_addr;
                    if (op_is_lit)
                        i_addr <= i_addr + 16'd1;
                end
                LIT_CAP: literal <= i_bus;
                VALID: begin
                    // Next address is derived from pc so it wraps modulo 2^16 like the PC itself.
                    if (accept)
                        i_addr <= pc + (has_literal ? 16'd2 : 16'd1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_fetch.sv
// Bench for cpu_fetch: directed scenarios plus a randomized run against a
// program-order model of the instruction stream.
module tb_cpu_fetch;

    localparam logic [7:0] LIT = 8'h1A;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] i_addr;
    logic [15:0] i_bus;
    logic [15:0] instr;
    logic [15:0] literal;
    logic        has_literal;
    logic [15:0] pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        jump;
    logic [15:0] jump_addr;

    logic [15:0] mem [0:65535];

    int vec  = 0;
    int errs = 0;

    cpu_fetch dut (
        .clk         (clk),
        .rst         (rst),
        .i_addr      (i_addr),
        .i_bus       (i_bus),
        .instr       (instr),
        .literal     (literal),
        .has_literal (has_literal),
        .pc          (pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .jump        (jump),
        .jump_addr   (jump_addr)
    );

    always #5 clk = ~clk;

    // Synchronous memory: address sampled on an edge, data held until the next.
    always @(posedge clk) i_bus <= mem[i_addr];

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, got timeout, wanted completion");
        $fatal(1);
    end

    // Ends at the negedge right after the single reset edge.
    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Called at the negedge following the triggering edge; n is the count of
    // negedges (this one included) until instr_valid is seen.
    task automatic wait_valid(output int n);
        n = 1;
        while (!instr_valid && n < 12) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; instr_ready = 1'b0; jump = 1'b0; jump_addr = 16'h0000;
        @(negedge clk);
        @(negedge clk);
        vec++; if (instr_valid !== 1'b0) begin errs++; $display("FAIL reset_valid: got %b wanted 0", instr_valid); end
        vec++; if (i_addr !== 16'h0000) begin errs++; $display("FAIL reset_i_addr: got %h wanted 0000", i_addr); end
        vec++; if (pc !== 16'h0000) begin errs++; $display("FAIL reset_pc: got %h wanted 0000", pc); end
        vec++; if (instr !== 16'h0000) begin errs++; $display("FAIL reset_instr: got %h wanted 0000", instr); end
        vec++; if (literal !== 16'h0000) begin errs++; $display("FAIL reset_literal: got %h wanted 0000", literal); end
        vec++; if (has_literal !== 1'b0) begin errs++; $display("FAIL reset_has_literal: got %b wanted 0", has_literal); end
    endtask

    task automatic test_basic();
        int n;
        instr_ready = 1'b1;
        do_reset();
        wait_valid(n);
        vec++; if (n != 5) begin errs++; $display("FAIL basic_first_latency: got %0d wanted 5", n); end
        vec++; if (instr !== 16'hFF1A || has_literal !== 1'b1 || literal !== 16'hAAAA || pc !== 16'h0000) begin
            errs++; $display("FAIL basic_first: got instr=%h lit=%b/%h pc=%h wanted FF1A 1/AAAA 0000", instr, has_literal, literal, pc);
        end
        @(negedge clk);
        wait_valid(n);
        vec++; if (n != 3) begin errs++; $display("FAIL basic_next_latency: got %0d wanted 3", n); end
        vec++; if (instr !== 16'hFF3A || has_literal !== 1'b0 || pc !== 16'h0002) begin
            errs++; $display("FAIL basic_next: got instr=%h lit=%b pc=%h wanted FF3A 0 0002", instr, has_literal, pc);
        end
        instr_ready = 1'b0;
    endtask

    task automatic test_stall();
        int n;
        logic [15:0] held_addr;
        instr_ready = 1'b0;
        do_reset();
        wait_valid(n);
        vec++; if (n != 5) begin errs++; $display("FAIL stall_latency: got %0d wanted 5", n); end
        held_addr = i_addr;
        vec++; if (held_addr !== 16'h0001) begin errs++; $display("FAIL stall_addr: got %h wanted 0001", held_addr); end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            vec++;
            if (instr_valid !== 1'b1 || instr !== 16'hFF1A || literal !== 16'hAAAA || pc !== 16'h0000 || i_addr !== held_addr) begin
                errs++;
                $display("FAIL stall_hold[%0d]: got v=%b instr=%h lit=%h pc=%h addr=%h wanted 1 FF1A AAAA 0000 %h",
                         i, instr_valid, instr, literal, pc, i_addr, held_addr);
            end
        end
        instr_ready = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;
        wait_valid(n);
        vec++; if (n != 3 || pc !== 16'h0002 || instr !== 16'hFF3A) begin
            errs++; $display("FAIL stall_release: got n=%0d pc=%h instr=%h wanted 3 0002 FF3A", n, pc, instr);
        end
    endtask

    task automatic test_jump_lit_wait();
        int n;
        instr_ready = 1'b0;
        do_reset();
        @(negedge clk);
        @(negedge clk);
        jump = 1'b1; jump_addr = 16'h0002;
        @(negedge clk);
        jump = 1'b0;
        wait_valid(n);
        vec++; if (n != 3 || pc !== 16'h0002 || instr !== 16'hFF3A || has_literal !== 1'b0) begin
            errs++; $display("FAIL jump_lit_wait: got n=%0d pc=%h instr=%h hl=%b wanted 3 0002 FF3A 0", n, pc, instr, has_literal);
        end
    endtask

    task automatic test_jump_accept();
        int n;
        instr_ready = 1'b0;
        do_reset();
        wait_valid(n);
        instr_ready = 1'b1; jump = 1'b1; jump_addr = 16'h0004;
        @(negedge clk);
        instr_ready = 1'b0; jump = 1'b0;
        wait_valid(n);
        vec++; if (n != 3 || pc !== 16'h0004 || instr !== 16'hFF3F || has_literal !== 1'b0) begin
            errs++; $display("FAIL jump_accept: got n=%0d pc=%h instr=%h hl=%b wanted 3 0004 FF3F 0", n, pc, instr, has_literal);
        end
    endtask

    task automatic test_wrap();
        int n;
        mem[16'h0000] = 16'h1234;
        instr_ready = 1'b0;
        do_reset();
        jump = 1'b1; jump_addr = 16'hFFFF;
        @(negedge clk);
        jump = 1'b0;
        wait_valid(n);
        vec++; if (n != 5 || instr !== 16'hFF1A || has_literal !== 1'b1 || literal !== 16'h1234 || pc !== 16'hFFFF) begin
            errs++; $display("FAIL wrap_literal: got n=%0d instr=%h hl=%b lit=%h pc=%h wanted 5 FF1A 1 1234 FFFF",
                             n, instr, has_literal, literal, pc);
        end
        instr_ready = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;
        vec++; if (i_addr !== 16'h0001) begin errs++; $display("FAIL wrap_next_addr: got %h wanted 0001", i_addr); end
        wait_valid(n);
        vec++; if (n != 3 || pc !== 16'h0001 || instr !== 16'hAAAA) begin
            errs++; $display("FAIL wrap_next: got n=%0d pc=%h instr=%h wanted 3 0001 AAAA", n, pc, instr);
        end
    endtask

    task automatic test_rst_mid();
        int n;
        int want;
        want = (mem[16'h0000][7:0] == LIT) ? 5 : 3;
        instr_ready = 1'b0;
        do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        vec++; if (instr_valid !== 1'b0 || i_addr !== 16'h0000) begin
            errs++; $display("FAIL rst_op_cap: got v=%b addr=%h wanted 0 0000", instr_valid, i_addr);
        end
        rst = 1'b0;
        wait_valid(n);
        vec++; if (n != want || pc !== 16'h0000) begin
            errs++; $display("FAIL rst_op_cap_restart: got n=%0d pc=%h wanted %0d 0000", n, pc, want);
        end
        rst = 1'b1;
        @(negedge clk);
        vec++; if (instr_valid !== 1'b0 || i_addr !== 16'h0000) begin
            errs++; $display("FAIL rst_valid: got v=%b addr=%h wanted 0 0000", instr_valid, i_addr);
        end
        rst = 1'b0;
        wait_valid(n);
        vec++; if (n != want || pc !== 16'h0000) begin
            errs++; $display("FAIL rst_valid_restart: got n=%0d pc=%h wanted %0d 0000", n, pc, want);
        end
    endtask

    // The model only tracks which address execute should see next; the
    // instruction shape and latency follow from the memory contents there.
    task automatic test_random();
        logic [15:0] exp_pc;
        logic [15:0] nxt;
        logic        islit;
        int          lat;
        bit          pend;
        for (int a = 0; a < 65536; a++) begin
            mem[a] = 16'($urandom);
            if ($urandom_range(0, 2) == 0) mem[a][7:0] = LIT;
        end
        instr_ready = 1'b0; jump = 1'b0;
        do_reset();
        exp_pc = 16'h0000; pend = 1'b1; lat = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            islit = (mem[exp_pc][7:0] == LIT);
            nxt   = exp_pc + 16'd1;
            if (pend) lat++;
            if (instr_valid) begin
                if (pend) begin
                    vec++;
                    if (lat != (islit ? 5 : 3)) begin
                        errs++; $display("FAIL rand_latency: got %0d wanted %0d at pc %h", lat, islit ? 5 : 3, exp_pc);
                    end
                    pend = 1'b0;
                end
                vec++;
                if (pc !== exp_pc || instr !== mem[exp_pc] || has_literal !== islit || (islit && literal !== mem[nxt])) begin
                    errs++;
                    $display("FAIL rand_instr: got pc=%h instr=%h hl=%b lit=%h wanted %h %h %b %h",
                             pc, instr, has_literal, literal, exp_pc, mem[exp_pc], islit, mem[nxt]);
                end
            end else if (!pend) begin
                vec++; errs++;
                $display("FAIL rand_valid_drop: got valid=0 wanted 1 at pc %h", exp_pc);
                pend = 1'b1; lat = 0;
            end else if (lat > 6) begin
                vec++; errs++;
                $display("FAIL rand_timeout: got no valid after %0d wanted %0d", lat, islit ? 5 : 3);
                pend = 1'b1; lat = 0;
            end
            instr_ready = 1'($urandom_range(0, 1));
            jump        = ($urandom_range(0, 15) == 0);
            jump_addr   = ($urandom_range(0, 3) == 0) ? 16'(16'hFFFC + $urandom_range(0, 3)) : 16'($urandom);
            if (jump) begin
                exp_pc = jump_addr; pend = 1'b1; lat = 0;
            end else if (instr_valid && instr_ready) begin
                exp_pc = exp_pc + (islit ? 16'd2 : 16'd1); pend = 1'b1; lat = 0;
            end
            @(negedge clk);
        end
        jump = 1'b0; instr_ready = 1'b0;
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) mem[a] = 16'h0000;
        mem[16'h0000] = 16'hFF1A;
        mem[16'h0001] = 16'hAAAA;
        mem[16'h0002] = 16'hFF3A;
        mem[16'h0003] = 16'h0000;
        mem[16'h0004] = 16'hFF3F;
        mem[16'hFFFF] = 16'hFF1A;
        test_reset();
        test_basic();
        test_stall();
        test_jump_lit_wait();
        test_jump_accept();
        test_wrap();
        test_rst_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule

// File: doc/cpu_fetch.md
Name: cpu_fetch

Overview:
- Instruction fetch stage between the instruction port of the synchronous memory and the CPU execute stage.
- Drives i_addr and captures the registered i_bus word.
- Detects literal-load opcodes and fetches the trailing literal word.
- Presents one complete instruction (opcode plus optional literal) to execute over a valid/ready handshake.
- Redirects on jump requests from execute.

Parameters:
RESET_ADDR, 16'h0000, PC/i_addr value after reset
LIT_CODE, 8'h1A, instruction low byte marking "next word is literal"

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
i_addr  output  16  instruction memory address (registered)
i_bus  input  16  instruction memory data, mem[i_addr] registered one cycle after address
instr  output  16  captured opcode word
literal  output  16  captured literal word (valid only when has_literal=1)
has_literal  output  1  instr[7:0]==LIT_CODE
pc  output  16  address of the presented instr
instr_valid  output  1  instr/literal/pc valid for execute
instr_ready  input  1  execute accepts when instr_valid && instr_ready
jump  input  1  redirect request, sampled every cycle
jump_addr  input  16  redirect target

Behaviour:
- Memory timing: address registered at edge e is sampled by memory at edge e+1; i_bus holds the data from e+1 to e+2. The fetch unit captures it at e+2.
- Reset values: i_addr=RESET_ADDR, pc=RESET_ADDR, instr=0, literal=0, has_literal=0, instr_valid=0, state=OP_WAIT.
- FSM states: OP_WAIT, OP_CAP, LIT_WAIT, LIT_CAP, VALID.
- OP_WAIT -> OP_CAP unconditionally (memory latency slot).
- OP_CAP:
  - instr<=i_bus, has_literal<=(i_bus[7:0]==LIT_CODE), pc<=i_addr.
  - If literal: i_addr<=i_addr+1, go to LIT_WAIT.
  - Otherwise go to VALID.
- LIT_WAIT -> LIT_CAP unconditionally.
- LIT_CAP: literal<=i_bus, go to VALID.
- VALID:
  - instr_valid=1.
  - Hold all outputs and i_addr while instr_ready=0; stall is unbounded.
  - On accept: i_addr<=pc+1 (plain) or pc+2 (literal), go to OP_WAIT.
- instr_valid is registered and equals 1 only in VALID.
- Latency:
  - First instr_valid rises 3 cycles after the rst-low edge (edges 1..3: OP_WAIT, OP_CAP, VALID).
  - Accept to next valid: 3 cycles for a plain instruction, 5 cycles when the next instruction carries a literal.
- Jump: when jump=1 on an edge in any state:
  - i_addr<=jump_addr, pc<=jump_addr, instr_valid<=0, go to OP_WAIT.
  - Any partially fetched instruction or literal is discarded.
- Priority: rst > jump > accept. Jump coincident with accept: the presented instruction counts as consumed and the next fetch comes from jump_addr, not the sequential address.
- Address arithmetic is 16-bit modulo:
  - A literal opcode at 16'hFFFF takes its literal from 16'h0000.
  - Sequential next after 16'hFFFF is 16'h0000; after a literal opcode at 16'hFFFE it is 16'h0000.
- rst mid-fetch (any state) returns to the reset values on that edge. No stale instr_valid after reset.
- literal retains its last value when has_literal=0. Execute must ignore it.
- No combinational path from any input to any output.

Test Plan:
- Memory {0:FF1A, 1:AAAA, 2:FF3A}, instr_ready=1 -> first valid: instr=FF1A, has_literal=1, literal=AAAA, pc=0. Next valid: instr=FF3A, has_literal=0, pc=2, exactly 3 cycles after the first accept.
- Same memory, instr_ready=0 for 10 cycles at the first valid -> instr_valid stays 1, outputs stable at FF1A/AAAA/pc=0, i_addr stable. After release, pc=2 is delivered.
- jump=1, jump_addr=0x0002 pulsed during LIT_WAIT of the first fetch -> literal fetch aborted. Next valid has pc=2, instr=FF3A, and nothing with pc=0 is delivered.
- Jump coincident with accept of pc=0, jump_addr=0x0004, mem[4]=FF3F -> next valid has pc=4, instr=FF3F, 3 cycles later. Address 2 is never presented as valid.
- Jump to 0xFFFF, mem[FFFF]=FF1A, mem[0]=1234 -> instr=FF1A, literal=1234, pc=FFFF. After accept, the next fetch address is 0x0001.
- rst asserted in OP_CAP and in VALID -> next cycle instr_valid=0, i_addr=RESET_ADDR. The first post-reset valid has pc=RESET_ADDR after 3 cycles.
